// File: rtl/kara_mul33_arb.sv
// Two-port front end for a shared pipelined 33x33 multiplier: round-robin issue,
// a tag pipeline that follows each product, and a credit-limited FWFT result FIFO per port.
module kara_mul33_arb #(
  parameter int unsigned MUL_LAT   = 4,
  parameter int unsigned RSP_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [32:0] req0_a,
  input  logic [32:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [32:0] req1_a,
  input  logic [32:0] req1_b,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [65:0] rsp0_p,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [65:0] rsp1_p,

  output logic [32:0] mul_a,
  output logic [32:0] mul_b,
  input  logic [65:0] mul_p,

  output logic        busy
);

  localparam int unsigned AW   = $clog2(RSP_DEPTH);
  localparam int unsigned CW   = $clog2(RSP_DEPTH + 1);
  localparam int unsigned LAST = MUL_LAT - 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(RSP_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {
    LAST_P0 = 1'b0,
    LAST_P1 = 1'b1
  } last_e;

  last_e last_q, last_d;

  logic [1:0]         req_valid;
  logic [1:0]         rsp_ready;
  logic [1:0]         elig;
  logic [1:0]         grant;
  logic [1:0]         push;
  logic [1:0]         fifo_ne;
  logic [1:0]         rsp_hs;
  logic               issue;

  logic [CW-1:0]      cnt_q  [2];
  logic [AW:0]        wr_ptr [2];
  logic [AW:0]        rd_ptr [2];
  logic [65:0]        mem    [2][RSP_DEPTH];

  logic [MUL_LAT-1:0] tag_v;
  logic [MUL_LAT-1:0] tag_id;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Eligibility uses only the registered credit count, so a pop never frees a slot in the same cycle.
  always_comb begin
    elig    = '0;
    fifo_ne = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      elig[p]    = req_valid[p] && (cnt_q[p] < CNT_MAX);
      fifo_ne[p] = (wr_ptr[p] != rd_ptr[p]);
    end
  end

  assign rsp_hs = fifo_ne & rsp_ready;

  always_comb begin
    grant  = '0;
    last_d = last_q;
    if (rst_n) begin
      if (elig == 2'b11) begin
        grant = (last_q == LAST_P1) ? 2'b01 : 2'b10;
      end else begin
        grant = elig;
      end
    end
    if (grant[0]) begin
      last_d = LAST_P0;
    end else if (grant[1]) begin
      last_d = LAST_P1;
    end
  end

  assign issue = |grant;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (grant[0]) begin
      mul_a = req0_a;
      mul_b = req0_b;
    end else if (grant[1]) begin
      mul_a = req1_a;
      mul_b = req1_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LAST_P1;
    end else begin
      last_q <= last_d;
    end
  end

  // Tag stage k holds the owner of the product that mul_p presents one edge after stage LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= issue;
      tag_id[0] <= grant[1];
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign push[0] = tag_v[LAST] && !tag_id[LAST];
  assign push[1] = tag_v[LAST] &&  tag_id[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < 2; p++) begin
        cnt_q[p]  <= '0;
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (push[p]) begin
          wr_ptr[p] <= wr_ptr[p] + PTR_ONE;
        end
        if (rsp_hs[p]) begin
          rd_ptr[p] <= rd_ptr[p] + PTR_ONE;
        end
        case ({grant[p], rsp_hs[p]})
          2'b10:   cnt_q[p] <= cnt_q[p] + CNT_ONE;
          2'b01:   cnt_q[p] <= cnt_q[p] - CNT_ONE;
          default: cnt_q[p] <= cnt_q[p];
        endcase
      end
    end
  end

  // Storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (push[p]) begin
        mem[p][wr_ptr[p][AW-1:0]] <= mul_p;
      end
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign rsp0_valid = fifo_ne[0];
  assign rsp1_valid = fifo_ne[1];
  assign rsp0_p     = mem[0][rd_ptr[0][AW-1:0]];
  assign rsp1_p     = mem[1][rd_ptr[1][AW-1:0]];

  assign busy = (|tag_v) | (|fifo_ne);

endmodule

// File: tb/tb_kara_mul33_arb.sv
// Directed bench for kara_mul33_arb; the shared multiplier is modelled as a plain product pipeline.
module tb_kara_mul33_arb;

  localparam int unsigned MUL_LAT   = 4;
  localparam int unsigned RSP_DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [32:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [65:0] rsp0_p, rsp1_p;
  logic [32:0] mul_a, mul_b;
  logic [65:0] mul_p;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int n_rsp0   = 0;

  logic [65:0] mpipe [MUL_LAT];

  logic [65:0] exp_alt0 [5] = '{66'd10, 66'd30, 66'd50, 66'd70, 66'd90};
  logic [65:0] exp_alt1 [5] = '{66'd303, 66'd309, 66'd315, 66'd321, 66'd327};
  logic [65:0] exp_drn1 [8] = '{66'd12, 66'd16, 66'd20, 66'd24, 66'd28, 66'd32, 66'd1000, 66'd1001};

  kara_mul33_arb #(
    .MUL_LAT   (MUL_LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_p     (rsp0_p),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_p     (rsp1_p),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External multiplier: not reset, MUL_LAT register stages.
  always_ff @(posedge clk) begin
    mpipe[0] <= {33'd0, mul_a} * {33'd0, mul_b};
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_p = mpipe[MUL_LAT-1];

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic obs0();
    if (rsp0_valid && rsp0_ready) n_rsp0++;
  endtask

  initial begin
    int k0, k1;

    // Reset state, with a request offered during reset.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 33'd3; req0_b = 33'd5;
    req1_valid = 1'b0; req1_a = '0;    req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #3;
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_mul_a", mul_a, 33'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", rsp1_valid, 1'b0);
    tick();
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // 3*5 on port 0: latency and busy span.
    req0_valid = 1'b1; req0_a = 33'd3; req0_b = 33'd5;
    #1;
    chk("lat_ready0", req0_ready, 1'b1);
    chk("lat_mul_a", mul_a, 33'd3);
    chk("lat_mul_b", mul_b, 33'd5);
    chk("lat_busy_pre", busy, 1'b0);
    tick();  // E
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    #1;
    chk("lat_busy_e", busy, 1'b1);
    chk("lat_valid_e", rsp0_valid, 1'b0);
    tick(); tick(); tick();  // E+3
    chk("lat_valid_e3", rsp0_valid, 1'b0);
    chk("lat_busy_e3", busy, 1'b1);
    tick();  // E+4
    chk("lat_valid_e4", rsp0_valid, 1'b1);
    chk("lat_p", rsp0_p, 66'd15);
    chk("lat_busy_e4", busy, 1'b1);
    rsp0_ready = 1'b1;
    tick();  // pop
    chk("lat_valid_pop", rsp0_valid, 1'b0);
    chk("lat_busy_pop", busy, 1'b0);
    rsp0_ready = 1'b0;

    // Port 1 extremes: max*max, then zero.
    req1_valid = 1'b1; req1_a = 33'h1_FFFF_FFFF; req1_b = 33'h1_FFFF_FFFF;
    #1;
    chk("max_ready1", req1_ready, 1'b1);
    tick();  // E
    req1_a = 33'd0; req1_b = 33'h1_2345;
    #1;
    chk("zero_ready1", req1_ready, 1'b1);
    tick();  // E+1
    req1_valid = 1'b0; rsp1_ready = 1'b1;
    tick(); tick(); tick();  // E+4
    chk("max_valid", rsp1_valid, 1'b1);
    chk("max_p", rsp1_p, 66'h3_FFFF_FFFC_0000_0001);
    tick();
    chk("zero_valid", rsp1_valid, 1'b1);
    chk("zero_p", rsp1_p, 66'd0);
    tick();
    chk("ext_empty", rsp1_valid, 1'b0);

    // Both ports valid for 10 cycles, responses always ready.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    k0 = 0; k1 = 0;
    for (int c = 0; c < 20; c++) begin
      req0_valid = (c < 10); req0_a = 33'(c + 1);   req0_b = 33'd10;
      req1_valid = (c < 10); req1_a = 33'(c + 100); req1_b = 33'd3;
      #1;
      if (c < 10) begin
        chk("alt_ready0", req0_ready, (c % 2 == 0));
        chk("alt_ready1", req1_ready, (c % 2 == 1));
      end
      if (rsp0_valid) begin
        if (k0 < 5) chk("alt_p0", rsp0_p, exp_alt0[k0]);
        k0++;
      end
      if (rsp1_valid) begin
        if (k1 < 5) chk("alt_p1", rsp1_p, exp_alt1[k1]);
        k1++;
      end
      tick();
    end
    chk("alt_cnt0", k0, 5);
    chk("alt_cnt1", k1, 5);

    // Port 1 response stalled: credit limit, port 0 unaffected.
    rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    n_rsp0 = 0;
    for (int c = 0; c < 24; c++) begin
      req0_valid = 1'b1; req0_a = 33'(c);     req0_b = 33'd1;
      req1_valid = 1'b1; req1_a = 33'(c + 1); req1_b = 33'd2;
      #1;
      chk("stall_ready0", req0_ready, (c < 16) ? (c % 2 == 0) : 1'b1);
      chk("stall_ready1", req1_ready, (c < 16) && (c % 2 == 1));
      obs0();
      tick();
    end
    chk("stall_head_valid", rsp1_valid, 1'b1);
    chk("stall_head_p", rsp1_p, 66'd4);
    // cnt = RSP_DEPTH with a pop: no accept this cycle.
    req0_valid = 1'b0;
    req1_a = 33'd1000; req1_b = 33'd1; rsp1_ready = 1'b1;
    #1;
    chk("full_pop_ready1", req1_ready, 1'b0);
    chk("full_pop_p", rsp1_p, 66'd4);
    obs0();
    tick();
    // cnt = RSP_DEPTH-1 with accept and pop together.
    #1;
    chk("resume_ready1", req1_ready, 1'b1);
    chk("resume_p", rsp1_p, 66'd8);
    obs0();
    tick();
    rsp1_ready = 1'b0; req1_a = 33'd1001;
    #1;
    chk("same_cnt_ready1", req1_ready, 1'b1);
    chk("same_cnt_p", rsp1_p, 66'd12);
    obs0();
    tick();
    #1;
    chk("refull_ready1", req1_ready, 1'b0);
    req1_valid = 1'b0; rsp1_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("drain_valid1", rsp1_valid, 1'b1);
      chk("drain_p1", rsp1_p, exp_drn1[k]);
      obs0();
      tick();
    end
    #1;
    chk("drain_empty1", rsp1_valid, 1'b0);
    chk("stall_rsp0_count", n_rsp0, 16);

    // Reset with three products in flight.
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_b = 33'd3;
    for (int i = 0; i < 3; i++) begin
      req0_a = 33'(i + 2);
      tick();
    end
    #1;
    rst_n = 1'b0;
    req1_valid = 1'b1; req1_a = 33'd5; req1_b = 33'd5;
    #1;
    chk("mid_rst_ready0", req0_ready, 1'b0);
    chk("mid_rst_ready1", req1_ready, 1'b0);
    chk("mid_rst_mul_a", mul_a, 33'd0);
    chk("mid_rst_mul_b", mul_b, 33'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rsp0", rsp0_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 33'd6;  req0_b = 33'd7;
    req1_valid = 1'b1; req1_a = 33'd11; req1_b = 33'd13;
    #1;
    chk("tie_ready0", req0_ready, 1'b1);
    chk("tie_ready1", req1_ready, 1'b0);
    chk("tie_mul_a", mul_a, 33'd6);
    tick();  // E
    req0_valid = 1'b0;
    #1;
    chk("tie2_ready1", req1_ready, 1'b1);
    chk("tie2_mul_a", mul_a, 33'd11);
    tick();  // E+1
    req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst_no_rsp0", rsp0_valid, 1'b0);
      tick();
    end
    // E+4
    chk("post_rst_valid0", rsp0_valid, 1'b1);
    chk("post_rst_p0", rsp0_p, 66'd42);
    chk("post_rst_no_rsp1", rsp1_valid, 1'b0);
    tick();
    chk("post_rst_valid1", rsp1_valid, 1'b1);
    chk("post_rst_p1", rsp1_p, 66'd143);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/kara_mul33_arb.md
KARA_MUL33_ARB -- requirements
Module: kara_mul33_arb

Interface
REQ-001 Parameter MUL_LAT, default 4, meaning: clock edges from the issue edge to the edge at which mul_p carries that product; legal range 1..16.
REQ-002 Parameter RSP_DEPTH, default 8, meaning: per-port result FIFO depth and credit limit; power of two, at least 2.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 req0_valid / req1_valid  in  1  port operand pair is offered.
REQ-006 req0_ready / req1_ready  out  1  port operand pair is accepted this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  in  33  unsigned operands.
REQ-008 rsp0_valid / rsp1_valid  out  1  port result is available at the FIFO head.
REQ-009 rsp0_ready / rsp1_ready  in  1  consumer takes the port result.
REQ-010 rsp0_p / rsp1_p  out  66  unsigned product at the FIFO head.
REQ-011 mul_a, mul_b  out  33  operands to the shared external pipelined 33x33 Karatsuba multiplier.
REQ-012 mul_p  in  66  product from the shared multiplier.
REQ-013 busy  out  1  a product is in flight or a FIFO is non-empty.

Function
REQ-014 Per-port credit counter cnt (0..RSP_DEPTH) = in-flight count + FIFO occupancy; port eligible iff reqN_valid and registered cnt < RSP_DEPTH; no same-cycle bypass from a response handshake.
REQ-015 At most one grant per cycle; sole eligible port is granted; both eligible -> port not granted last time; last-grant pointer resets to port 1, so port 0 wins the first tie.
REQ-016 reqN_ready = grant to N, combinational from valid and registered state; the handshake is reqN_valid & reqN_ready at the edge.
REQ-017 mul_a/mul_b = granted port's operands in the grant cycle, else 0.
REQ-018 Tag pipeline of MUL_LAT stages {valid, port id}: the stage-0 entry is loaded at each issue edge; with no issue, a valid=0 bubble is shifted in.
REQ-019 At edge E+MUL_LAT after issue edge E, mul_p is written into the FIFO of the tagged port; mul_p is ignored when the tag is invalid.
REQ-020 FIFO is first-word-fall-through: rspN_valid = non-empty, rspN_p = head; the head is popped on the rspN_valid & rspN_ready edge.
REQ-021 Minimum latency: accept at edge E -> rspN_valid high in the cycle after edge E+MUL_LAT.
REQ-022 cnt +1 on accept, -1 on response handshake; both at the same edge -> unchanged; cnt can never exceed RSP_DEPTH, so no FIFO overflow.
REQ-023 Results per port are returned in acceptance order; ports are mutually independent, and a stalled rsp port never blocks the other port.
REQ-024 FIFO read/write pointers wrap modulo RSP_DEPTH; a simultaneous push and pop on a full FIFO is impossible by REQ-022; on an empty FIFO a push and pop cannot coincide because valid is low.
REQ-025 busy = OR of the tag valids | any FIFO non-empty.
REQ-026 Sustained throughput with both ports eligible = one accept per cycle, strictly alternating.

Reset
REQ-027 rst_n low immediately clears: tag valids, cnt, FIFO pointers and last-grant pointer (to 1); reqN_ready, rspN_valid and busy are driven to 0; mul_a/mul_b are driven to 0.
REQ-028 The external multiplier is not reset; after release, stale mul_p values are never written because all tags are invalid.
REQ-029 Reset mid-operation discards all in-flight and buffered results; the first cycle after release accepts normally.
REQ-030 rspN_p after reset is don't-care while rspN_valid=0.

Verification
REQ-031 Port 0 issues a=3, b=5 at edge E with MUL_LAT=4 -> rsp0_valid=1 and rsp0_p=15 in the cycle after E+4; busy=1 from E through the pop.
REQ-032 a=b=0x1_FFFF_FFFF on port 1 -> rsp1_p=0x3_FFFF_FFFC_0000_0001; a=0 with any b -> 0.
REQ-033 Both ports valid for 10 cycles with responses always ready -> grants 0,1,0,1,... with 10 accepts; each port receives its 5 products in order.
REQ-034 rsp1_ready held 0 with port 1 continuously valid -> exactly 8 accepts, then req1_ready=0; port 0 keeps 1 accept per cycle; raising rsp1_ready drains 8 results in order, then acceptance resumes.
REQ-035 rst_n pulsed low with 3 products in flight -> outputs 0 asynchronously; after release, no rspN_valid until new requests complete.
REQ-036 cnt=RSP_DEPTH-1 with a simultaneous accept and pop -> cnt unchanged; at cnt=RSP_DEPTH, a pop in a cycle -> no accept that cycle, accept possible the next cycle.
